// File: rtl/keypad_pkg.sv
// Shared key codes, frame codes, position-to-key map and debounce FSM states.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: K0..K9, K_SIGN, K_BKSP, K_CLR, K_ENTER, K_IGN (4-bit key codes);
//           K_NONE, K_INV (5-bit frame codes); key_map(); kp_state_t.
package keypad_pkg;

   localparam logic [3:0] K0 = 4'd0;
   localparam logic [3:0] K1 = 4'd1;
   localparam logic [3:0] K2 = 4'd2;
   localparam logic [3:0] K3 = 4'd3;
   localparam logic [3:0] K4 = 4'd4;
   localparam logic [3:0] K5 = 4'd5;
   localparam logic [3:0] K6 = 4'd6;
   localparam logic [3:0] K7 = 4'd7;
   localparam logic [3:0] K8 = 4'd8;
   localparam logic [3:0] K9 = 4'd9;
   localparam logic [3:0] K_SIGN  = 4'd10;
   localparam logic [3:0] K_BKSP  = 4'd11;
   localparam logic [3:0] K_CLR   = 4'd12;
   localparam logic [3:0] K_ENTER = 4'd13;
   localparam logic [3:0] K_IGN   = 4'd14;

   // Frame codes: 0..15 is the single pressed position r*4+c; bit 4 set
   // marks "no key" or "several keys" so they can never alias a position.
   localparam logic [4:0] K_NONE = 5'h10;
   localparam logic [4:0] K_INV  = 5'h11;

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_t;

   // Row-major keypad legend, position r*4+c to key code.
   function automatic logic [3:0] key_map(input logic [3:0] pos);
      logic [3:0] k;
      case (pos)
         4'd0:    k = K1;
         4'd1:    k = K2;
         4'd2:    k = K3;
         4'd3:    k = K_SIGN;
         4'd4:    k = K4;
         4'd5:    k = K5;
         4'd6:    k = K6;
         4'd7:    k = K_BKSP;
         4'd8:    k = K7;
         4'd9:    k = K8;
         4'd10:   k = K9;
         4'd11:   k = K_CLR;
         4'd13:   k = K0;
         4'd14:   k = K_ENTER;
         default: k = K_IGN;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: synchronises rows, rotates the low column, reduces each frame to one code.
// Latency: frame_code/frame_done registered one cycle after the last slot of column 3.
// Backpressure: none; frame_done is a free-running one-cycle pulse per 4*SCAN_DIV cycles.
// Ports: clk, rst (async, active-high); row_n[3:0] raw active-low rows in;
//        col_n[3:0] active-low column drive out; frame_done pulse; frame_code[4:0].
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       frame_done,
   output logic [4:0] frame_code
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [3:0]    row_m;
   logic [3:0]    row_s;
   logic [DW-1:0] div_cnt;
   logic [1:0]    col;
   logic [1:0]    acc_n;     // low rows seen so far this frame, saturates at 2
   logic [3:0]    acc_pos;   // position of the single low row, if only one
   logic          slot_end;
   logic [2:0]    n_low;
   logic [2:0]    tot;
   logic [1:0]    r_idx;
   logic [3:0]    pos_nxt;

   assign slot_end = (div_cnt == DW'(SCAN_DIV - 1));
   assign col_n    = ~(4'b0001 << col);

   // Fold this column's sample into the running frame tally.
   always_comb begin
      n_low = 3'd0;
      r_idx = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s[r]) begin
            n_low = n_low + 3'd1;
            r_idx = 2'(r);
         end
      end
      tot     = {1'b0, acc_n} + n_low;
      pos_nxt = (n_low == 3'd1) ? {r_idx, col} : acc_pos;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_m      <= 4'hF;
         row_s      <= 4'hF;
         div_cnt    <= '0;
         col        <= 2'd0;
         acc_n      <= 2'd0;
         acc_pos    <= 4'd0;
         frame_done <= 1'b0;
         frame_code <= K_NONE;
      end else begin
         row_m      <= row_n;
         row_s      <= row_m;
         frame_done <= 1'b0;
         if (slot_end) begin
            div_cnt <= '0;
            col     <= col + 2'd1;
            if (col == 2'd3) begin
               frame_done <= 1'b1;
               frame_code <= (tot == 3'd0) ? K_NONE :
                             (tot == 3'd1) ? {1'b0, pos_nxt} : K_INV;
               acc_n      <= 2'd0;
               acc_pos    <= 4'd0;
            end else begin
               acc_n   <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
               acc_pos <= pos_nxt;
            end
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// Keypad operand entry: debounces scanned keys and accumulates a signed 3-digit operand.
// Latency: action lands one cycle after the deciding frame's code is presented.
// Backpressure: none; valid is a one-cycle strobe, bin/sgn hold until the next edit key.
// Ports: clk, rst (async, active-high); col_n[3:0] out, row_n[3:0] in;
//        bin[7:0], sgn, ndig[1:0], err (sticky), valid (one-cycle strobe).
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
)
(
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] col_n,
   input  logic [3:0] row_n,
   output logic [7:0] bin,
   output logic       sgn,
   output logic [1:0] ndig,
   output logic       err,
   output logic       valid
);

   localparam logic [3:0] DB = 4'(DEBOUNCE);

   logic        frame_done;
   logic [4:0]  frame_code;
   kp_state_t   state, state_nxt;
   logic [3:0]  cnt, cnt_nxt, cnt_inc;
   logic [4:0]  cand, cand_nxt;
   logic        fire;
   logic        done;      // an ENTER was accepted; next digit starts afresh
   logic [3:0]  key;
   logic [7:0]  base_bin;
   logic        base_sgn;
   logic [1:0]  base_ndig;
   logic [11:0] prod;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk        (clk),
      .rst        (rst),
      .row_n      (row_n),
      .col_n      (col_n),
      .frame_done (frame_done),
      .frame_code (frame_code)
   );

   assign cnt_inc = cnt + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         cand  <= K_NONE;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cand  <= cand_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      fire      = 1'b0;
      if (frame_done) begin
         case (state)
            IDLE: begin
               if (!frame_code[4]) begin
                  cand_nxt = frame_code;
                  cnt_nxt  = 4'd1;
                  if (DB == 4'd1) begin
                     fire      = 1'b1;
                     state_nxt = HELD;
                  end else begin
                     state_nxt = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (frame_code == cand) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == DB) begin
                     fire      = 1'b1;
                     state_nxt = HELD;
                  end
               end else begin
                  state_nxt = IDLE;
               end
            end
            HELD: begin
               // Any non-empty frame keeps us here: no repeat, second keys ignored.
               if (frame_code == K_NONE) begin
                  cnt_nxt   = 4'd1;
                  state_nxt = (DB == 4'd1) ? IDLE : REL_DB;
               end
            end
            REL_DB: begin
               if (frame_code == K_NONE) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == DB) state_nxt = IDLE;
               end else begin
                  state_nxt = HELD;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // fire only occurs while frame_code still equals the debounced candidate.
   assign key       = key_map(frame_code[3:0]);
   assign base_bin  = done ? 8'd0 : bin;
   assign base_sgn  = done ? 1'b0 : sgn;
   assign base_ndig = done ? 2'd0 : ndig;
   assign prod      = ({4'd0, base_bin} << 3) + ({4'd0, base_bin} << 1) + {8'd0, key};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin   <= 8'd0;
         sgn   <= 1'b0;
         ndig  <= 2'd0;
         err   <= 1'b0;
         done  <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (fire) begin
            if (key <= K9) begin
               done <= 1'b0;
               sgn  <= base_sgn;
               if (base_ndig == 2'd3 || prod > 12'd255) begin
                  err  <= 1'b1;
                  bin  <= base_bin;
                  ndig <= base_ndig;
               end else begin
                  bin  <= prod[7:0];
                  ndig <= base_ndig + 2'd1;
               end
            end else begin
               case (key)
                  K_SIGN: begin
                     sgn  <= ~sgn;
                     done <= 1'b0;
                  end
                  K_BKSP: begin
                     done <= 1'b0;
                     if (ndig != 2'd0) begin
                        bin  <= bin / 8'd10;
                        ndig <= ndig - 2'd1;
                     end
                  end
                  K_CLR: begin
                     bin  <= 8'd0;
                     sgn  <= 1'b0;
                     ndig <= 2'd0;
                     err  <= 1'b0;
                     done <= 1'b0;
                  end
                  K_ENTER: begin
                     if (!err) begin
                        valid <= 1'b1;
                        done  <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry with SCAN_DIV=4, DEBOUNCE=2 (one frame = 16 cycles).
// Latency: n/a.
// Backpressure: n/a.
// Ports: none; drives a 4x4 matrix model onto row_n from col_n and a pressed-key mask.
module tb_keypad_entry;

   localparam int SD = 4;
   localparam int FR = 4 * SD;

   // Keypad positions r*4+c.
   localparam int P1 = 0,  P2 = 1,  P3 = 2,  PSIGN = 3;
   localparam int P4 = 4,  P5 = 5,  P6 = 6,  PBKSP = 7;
   localparam int P7 = 8,  P8 = 9,  P9 = 10, PCLR  = 11;
   localparam int PIG0 = 12, P0 = 13, PENT = 14, PIG1 = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [7:0] bin;
   logic       sgn;
   logic [1:0] ndig;
   logic       err;
   logic       valid;
   logic [15:0] keys;

   always #5 clk = ~clk;

   keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .col_n (col_n),
      .row_n (row_n),
      .bin   (bin),
      .sgn   (sgn),
      .ndig  (ndig),
      .err   (err),
      .valid (valid)
   );

   // Passive matrix: a row reads low when a pressed key joins it to a low column.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_n[r] = 1'b1;
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
   end

   int   vcnt = 0;
   int   vdbl = 0;
   logic vprev = 1'b0;
   always @(negedge clk) begin
      if (valid) vcnt++;
      if (valid && vprev) vdbl++;
      vprev = valid;
   end

   int n_pass = 0;
   int n_total = 0;
   int v0 = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic chk_out(input string nm, input int b, input int s, input int n,
                          input int e, input int v);
      chk({nm, ".bin"},   int'(bin),  b);
      chk({nm, ".sgn"},   int'(sgn),  s);
      chk({nm, ".ndig"},  int'(ndig), n);
      chk({nm, ".err"},   int'(err),  e);
      chk({nm, ".valid"}, vcnt - v0,  v);
   endtask

   // Reference calculator: one call per completed keystroke.
   int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 13, 14};
   int m_bin, m_sgn, m_nd, m_err, m_done, m_v;

   task automatic model_reset();
      m_bin = 0; m_sgn = 0; m_nd = 0; m_err = 0; m_done = 0; m_v = 0;
   endtask

   task automatic model_key(input int pos);
      int k;
      k = kmap[pos];
      m_v = 0;
      if (k <= 9) begin
         if (m_done != 0) begin
            m_bin = 0; m_sgn = 0; m_nd = 0; m_done = 0;
         end
         if (m_nd == 3 || m_bin * 10 + k > 255) m_err = 1;
         else begin
            m_bin = m_bin * 10 + k;
            m_nd++;
         end
      end else if (k == 10) begin
         m_sgn = 1 - m_sgn; m_done = 0;
      end else if (k == 11) begin
         m_done = 0;
         if (m_nd > 0) begin
            m_bin = m_bin / 10;
            m_nd--;
         end
      end else if (k == 12) begin
         m_bin = 0; m_sgn = 0; m_nd = 0; m_err = 0; m_done = 0;
      end else if (k == 13) begin
         if (m_err == 0) begin
            m_v = 1; m_done = 1;
         end
      end
   endtask

   task automatic tap(input int pos, input int hold, input int gap);
      keys[pos] = 1'b1;
      repeat (hold) @(negedge clk);
      keys[pos] = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   typedef struct {
      int pos;
      int b;
      int s;
      int n;
      int e;
      int v;
   } vec_t;

   vec_t tbl [25];

   initial begin
      tbl[0]  = '{P2,    2,   0, 1, 0, 0};
      tbl[1]  = '{P5,    25,  0, 2, 0, 0};
      tbl[2]  = '{P5,    255, 0, 3, 0, 0};
      tbl[3]  = '{PENT,  255, 0, 3, 0, 1};
      tbl[4]  = '{P2,    2,   0, 1, 0, 0};
      tbl[5]  = '{P5,    25,  0, 2, 0, 0};
      tbl[6]  = '{P6,    25,  0, 2, 1, 0};
      tbl[7]  = '{PENT,  25,  0, 2, 1, 0};
      tbl[8]  = '{PCLR,  0,   0, 0, 0, 0};
      tbl[9]  = '{PIG0,  0,   0, 0, 0, 0};
      tbl[10] = '{P1,    1,   0, 1, 0, 0};
      tbl[11] = '{P2,    12,  0, 2, 0, 0};
      tbl[12] = '{PSIGN, 12,  1, 2, 0, 0};
      tbl[13] = '{PBKSP, 1,   1, 1, 0, 0};
      tbl[14] = '{PENT,  1,   1, 1, 0, 1};
      tbl[15] = '{P9,    9,   0, 1, 0, 0};
      tbl[16] = '{PCLR,  0,   0, 0, 0, 0};
      tbl[17] = '{PBKSP, 0,   0, 0, 0, 0};
      tbl[18] = '{P0,    0,   0, 1, 0, 0};
      tbl[19] = '{P0,    0,   0, 2, 0, 0};
      tbl[20] = '{P1,    1,   0, 3, 0, 0};
      tbl[21] = '{P2,    1,   0, 3, 1, 0};
      tbl[22] = '{PBKSP, 0,   0, 2, 1, 0};
      tbl[23] = '{PSIGN, 0,   1, 2, 1, 0};
      tbl[24] = '{PCLR,  0,   0, 0, 0, 0};

      keys = '0;
      rst  = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst.col_n", int'(col_n), 14);
      chk_out("rst", 0, 0, 0, 0, 0);
      chk("rst.valid_lvl", int'(valid), 0);

      // Column rotation straight out of reset, no keys.
      rst = 1'b0;
      for (int i = 0; i < 4 * FR; i++) begin
         chk($sformatf("col_rot%0d", i), int'(col_n), 15 ^ (1 << ((i / SD) % 4)));
         @(negedge clk);
      end
      chk_out("idle", 0, 0, 0, 0, 0);

      // Table of keystrokes with fixed expectations.
      for (int i = 0; i < 25; i++) begin
         v0 = vcnt;
         tap(tbl[i].pos, 4 * FR, 4 * FR);
         model_key(tbl[i].pos);
         chk_out($sformatf("vec%0d", i), tbl[i].b, tbl[i].s, tbl[i].n, tbl[i].e, tbl[i].v);
      end

      // Key visible for a single frame only: filtered out.
      v0 = vcnt;
      tap(P7, FR, 4 * FR);
      chk_out("glitch1", 0, 0, 0, 0, 0);

      // One-frame bounce-open in the middle of a hold: still one digit.
      v0 = vcnt;
      keys[P7] = 1'b1;
      repeat (3 * FR) @(negedge clk);
      keys[P7] = 1'b0;
      repeat (FR) @(negedge clk);
      keys[P7] = 1'b1;
      repeat (3 * FR) @(negedge clk);
      keys[P7] = 1'b0;
      repeat (4 * FR) @(negedge clk);
      model_key(P7);
      chk_out("bounce", 7, 0, 1, 0, 0);

      // Two keys in one column: invalid frames, then the survivor registers.
      v0 = vcnt;
      tap(PCLR, 4 * FR, 4 * FR);
      model_key(PCLR);
      keys[P1] = 1'b1;
      keys[P4] = 1'b1;
      repeat (4 * FR) @(negedge clk);
      chk_out("multi", 0, 0, 0, 0, 0);
      keys[P4] = 1'b0;
      repeat (4 * FR) @(negedge clk);
      keys[P1] = 1'b0;
      repeat (4 * FR) @(negedge clk);
      model_key(P1);
      chk_out("multi_rel", 1, 0, 1, 0, 0);

      // Reset while a key is held: it is accepted again afterwards, once.
      v0 = vcnt;
      keys[P9] = 1'b1;
      repeat (4 * FR) @(negedge clk);
      chk_out("pre_rst", 19, 0, 2, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_out("in_rst", 0, 0, 0, 0, 0);
      chk("in_rst.col_n", int'(col_n), 14);
      rst = 1'b0;
      repeat (4 * FR) @(negedge clk);
      model_reset();
      model_key(P9);
      chk_out("post_rst", 9, 0, 1, 0, 0);
      keys[P9] = 1'b0;
      repeat (4 * FR) @(negedge clk);
      chk_out("post_rel", 9, 0, 1, 0, 0);

      // Random keystrokes with random phase and hold/release lengths.
      v0 = vcnt;
      tap(PCLR, 4 * FR, 4 * FR);
      model_key(PCLR);
      chk_out("rnd_clr", m_bin, m_sgn, m_nd, m_err, m_v);
      for (int i = 0; i < 40; i++) begin
         int pos;
         pos = int'($urandom_range(0, 15));
         repeat ($urandom_range(0, FR - 1)) @(negedge clk);
         v0 = vcnt;
         tap(pos, 3 * FR + int'($urandom_range(0, 2 * FR)), 3 * FR + int'($urandom_range(0, 2 * FR)));
         model_key(pos);
         chk_out($sformatf("rnd%0d_p%0d", i, pos), m_bin, m_sgn, m_nd, m_err, m_v);
      end

      chk("valid_width", vdbl, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
